cond_compare_pipe: RTL and testbench
====================================

COND_COMPARE_PIPE -- requirements
Module: cond_compare_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..64).
REQ-002 Parameter CNT_W, default 16, hit-counter width in bits (legal range 1..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream asserts a valid operand/condition set.
REQ-006 in_ready  output  1  block can accept input this cycle.
REQ-007 a  input  WIDTH  left operand.
REQ-008 b  input  WIDTH  right operand.
REQ-009 cond  input  4  cond[2:0] = condition code; cond[3] = 1 for unsigned ordering, 0 for signed ordering.
REQ-010 out_valid  output  1  result register holds an unconsumed result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 result  output  1  evaluated condition; 1 = true, 0 = false.
REQ-013 clr_count  input  1  synchronous clear of hit_count.
REQ-014 hit_count  output  CNT_W  number of true results consumed downstream, saturating.

Function
REQ-015 Condition codes: 000 never (0); 001 a==b; 010 a<b; 011 a<=b; 100 always (1); 101 a!=b; 110 a>=b; 111 a>b.
REQ-016 Ordering codes (010, 011, 110, 111) compare in two's complement when cond[3]=0 and as unsigned when cond[3]=1.
REQ-017 Codes 000, 001, 100 and 101 ignore cond[3].
REQ-018 With b=0 and cond[3]=0, the evaluation equals the legacy single-operand signed zero-test semantics for all eight codes.
REQ-019 in_ready = !out_valid || out_ready (combinational); no other input-to-output combinational path.
REQ-020 Input transfer occurs when in_valid && in_ready at a rising edge.
REQ-021 On transfer, the evaluated condition is registered into result and out_valid is set to 1 on the same edge; latency is exactly 1 cycle.
REQ-022 Output transfer occurs when out_valid && out_ready at a rising edge.
REQ-023 When out_valid=1 and out_ready=0, result and out_valid are held unchanged, and in_ready=0.
REQ-024 Simultaneous output transfer and input transfer in the same cycle: the new result replaces the old one and out_valid stays 1, giving full throughput of one result per cycle.
REQ-025 Output transfer without input transfer: out_valid is cleared to 0 on that edge, and result holds its last value.
REQ-026 a, b and cond are sampled only on input transfer; changes while in_ready=0 have no effect.
REQ-027 hit_count increments by 1 on each output transfer with result=1.
REQ-028 hit_count saturates at 2^CNT_W-1 and does not wrap.
REQ-029 clr_count=1 sets hit_count to 0 on the next edge and takes priority over a simultaneous increment.

Reset
REQ-030 While rst=1: out_valid=0, result=0, hit_count=0, and in_ready=1, asynchronously and independent of clk.
REQ-031 Reset asserted mid-operation discards any pending unconsumed result; no partial transfer is counted.
REQ-032 The first input transfer is possible on the first rising edge after rst deasserts.

Verification
REQ-033 WIDTH=8: a=8'h80, b=8'h01, cond=4'b0010 -> result=1 (signed -128<1); same operands with cond=4'b1010 -> result=0 (unsigned 128<1 false).
REQ-034 Legacy sweep: b=0, cond[3]=0, a over {-128,-1,0,1,127}, all 8 codes -> results match REQ-015 (e.g. a=0, code 011 -> 1; a=0, code 111 -> 0).
REQ-035 Backpressure: out_ready=0 for 5 cycles after one transfer (a=3, b=3, code 001) -> result=1 held, out_valid=1, in_ready=0, and a/b changes are ignored; then out_ready=1 -> one output transfer, hit_count=1.
REQ-036 Streaming: in_valid=1 and out_ready=1 for 10 cycles, code 100 -> out_valid=1 every cycle from cycle 2, and hit_count=10 one edge after the last output transfer.
REQ-037 CNT_W=2: 5 consumed true results -> hit_count=3 (saturated); clr_count asserted in the same cycle as a true output transfer -> hit_count=0.
REQ-038 Assert rst asynchronously between edges while out_valid=1 -> out_valid=0 and result=0 immediately, hit_count=0, and in_ready=1.

Source files
------------

// File: rtl/cond_compare_pipe.sv
// Evaluates a condition code over two operands and reports the outcome as a 1-bit result; counts consumed true results.
// Latency: one cycle, one result per cycle. Backpressure: a held result stalls input via in_ready = !out_valid || out_ready.
module cond_compare_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  input  logic             clr_count,
  output logic [CNT_W-1:0] hit_count
);

  logic eq;
  logic lt;
  logic eval;
  logic in_xfer;
  logic out_xfer;

  // cond[3] selects unsigned ordering; equality tests are sign-agnostic
  always_comb begin
    eq = (a == b);
    lt = cond[3] ? (a < b) : ($signed(a) < $signed(b));
    eval = 1'b0;
    case (cond[2:0])
      3'b000: eval = 1'b0;
      3'b001: eval = eq;
      3'b010: eval = lt;
      3'b011: eval = lt | eq;
      3'b100: eval = 1'b1;
      3'b101: eval = !eq;
      3'b110: eval = !lt;
      3'b111: eval = !(lt | eq);
      default: eval = 1'b0;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      result    <= eval;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // clear wins over a coincident increment; the count sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count <= '0;
    end else if (clr_count) begin
      hit_count <= '0;
    end else if (out_xfer && result && (hit_count != {CNT_W{1'b1}})) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_compare_pipe.sv
// Randomized and directed checks of cond_compare_pipe against a transaction-level model.
module tb_cond_compare_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] cond;
  logic       out_ready;
  logic       clr_count;

  logic        in_ready,  out_valid,  result;
  logic [15:0] hit_count;
  logic        in_ready2, out_valid2, result2;
  logic [1:0]  hit_count2;

  int total = 0;
  int bad   = 0;

  // model state
  logic mv;
  logic mr;
  int   mc;
  int   mc2;

  always #5 clk = ~clk;

  cond_compare_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cond(cond), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .clr_count(clr_count), .hit_count(hit_count)
  );

  cond_compare_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .cond(cond), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .clr_count(clr_count), .hit_count(hit_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_eval(input logic [7:0] x, input logic [7:0] y, input logic [3:0] c);
    int xi;
    int yi;
    if (c[3]) begin
      xi = int'(x);
      yi = int'(y);
    end else begin
      xi = (x > 8'd127) ? int'(x) - 256 : int'(x);
      yi = (y > 8'd127) ? int'(y) - 256 : int'(y);
    end
    case (c[2:0])
      3'd0: return 1'b0;
      3'd1: return xi == yi;
      3'd2: return xi < yi;
      3'd3: return xi <= yi;
      3'd4: return 1'b1;
      3'd5: return xi != yi;
      3'd6: return xi >= yi;
      default: return xi > yi;
    endcase
  endfunction

  task automatic model_reset();
    mv = 1'b0; mr = 1'b0; mc = 0; mc2 = 0;
  endtask

  // one clock edge: advance the model with the inputs as driven, then compare
  task automatic step();
    logic inx, outx, ev;
    inx  = in_valid && (!mv || out_ready);
    outx = mv && out_ready;
    ev   = ref_eval(a, b, cond);
    @(posedge clk);
    if (clr_count) begin
      mc = 0; mc2 = 0;
    end else if (outx && mr) begin
      if (mc < 65535) mc++;
      if (mc2 < 3) mc2++;
    end
    if (inx) begin
      mr = ev; mv = 1'b1;
    end else if (outx) begin
      mv = 1'b0;
    end
    #1;
    check("out_valid", out_valid, mv);
    check("result", result, mr);
    check("hit_count", hit_count, mc);
    check("hit_count_sat", hit_count2, mc2);
    check("in_ready", in_ready, !mv || out_ready);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b1;
    step();
    clr_count = 1'b0;
  endtask

  initial begin
    logic [7:0] avals [5];
    avals = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cond = '0;
    out_ready = 1'b0; clr_count = 1'b0;
    model_reset();
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_result", result, 1'b0);
    check("rst_count", hit_count, 0);
    check("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // signed vs unsigned ordering; the first edge after reset accepts input
    in_valid = 1'b1; out_ready = 1'b1; a = 8'h80; b = 8'h01; cond = 4'b0010;
    step();
    check("signed_lt", result, 1'b1);
    cond = 4'b1010;
    step();
    check("unsigned_lt", result, 1'b0);

    // zero-test sweep with b=0, signed
    b = 8'h00;
    foreach (avals[i]) begin
      for (int c = 0; c < 8; c++) begin
        a = avals[i]; cond = 4'(c);
        step();
        if (avals[i] == 8'h00 && c == 3) check("zero_le", result, 1'b1);
        if (avals[i] == 8'h00 && c == 7) check("zero_gt", result, 1'b0);
      end
    end

    // backpressure: held result ignores operand changes
    drain();
    in_valid = 1'b1; a = 8'd3; b = 8'd3; cond = 4'b0001; out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); cond = 4'b0000;
      step();
      check("bp_result", result, 1'b1);
      check("bp_valid", out_valid, 1'b1);
      check("bp_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_count", hit_count, 1);
    check("bp_drained", out_valid, 1'b0);

    // streaming: ten always-true results at full rate
    drain();
    in_valid = 1'b1; out_ready = 1'b1; cond = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stream_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("stream_count", hit_count, 10);
    check("stream_sat", hit_count2, 3);

    // clear takes priority over a coincident true output transfer
    in_valid = 1'b1; cond = 4'b0100;
    step();
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    check("clr_prio", hit_count, 0);
    check("clr_prio_sat", hit_count2, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      cond = 4'($urandom);
      clr_count = ($urandom_range(0, 40) == 0);
      step();
    end
    clr_count = 1'b0;

    // async reset while a result is pending
    in_valid = 1'b1; out_ready = 1'b0; cond = 4'b0100;
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_result", result, 1'b0);
    check("arst_count", hit_count, 0);
    check("arst_ready", in_ready, 1'b1);
    model_reset();
    #1 rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; a = 8'd5; b = 8'd9; cond = 4'b1010;
    step();
    check("post_rst_xfer", out_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
